// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM command scheduler.
package sdram_arb_pkg;

    localparam int ADDR_W_DEF = 24;
    localparam int LEN_W_DEF  = 10;

    typedef enum logic [1:0] {
        CMD_REF = 2'd0,
        CMD_WR  = 2'd1,
        CMD_RD  = 2'd2
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_e;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Command handshake between the scheduler (master) and the SDRAM command engine (slave).
interface sdram_arbiter_if
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
);
    logic              cmd_req;
    cmd_e              cmd_type;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_ack;
    logic              cmd_done;

    modport master (
        output cmd_req, cmd_type, cmd_addr, cmd_len,
        input  cmd_ack, cmd_done
    );

    modport slave (
        input  cmd_req, cmd_type, cmd_addr, cmd_len,
        output cmd_ack, cmd_done
    );
endinterface

// File: rtl/sdram_addr_ptr.sv
// Wrapping SDRAM burst address pointer for one channel; a load overrides a completion.
module sdram_addr_ptr
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              done,
    input  logic [ADDR_W-1:0] min_addr,
    input  logic [ADDR_W-1:0] max_addr,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] ptr
);
    // One extra bit so a burst ending past the top of the address space still wraps.
    logic [ADDR_W:0] nxt;

    assign nxt = {1'b0, ptr} + (ADDR_W+1)'(len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= min_addr;
        end else if (done) begin
            ptr <= (nxt >= {1'b0, max_addr}) ? min_addr : nxt[ADDR_W-1:0];
        end
    end
endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM command scheduler: refresh timer, write/read burst selection, request/ack/done handshake.
// Define SDRAM_ARB_RR_EN to alternate write and read grants; otherwise write has priority.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int REF_PERIOD = 781,
    parameter int FIFO_DEPTH = 1024,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int LEN_W      = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sdram_init_done,
    input  logic [LEN_W:0]    wr_fifo_level,
    input  logic [LEN_W:0]    rd_fifo_level,
    input  logic [ADDR_W-1:0] wr_min_addr,
    input  logic [ADDR_W-1:0] wr_max_addr,
    input  logic [ADDR_W-1:0] rd_min_addr,
    input  logic [ADDR_W-1:0] rd_max_addr,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic [LEN_W-1:0]  rd_len,
    input  logic              wr_load,
    input  logic              rd_load,
    input  logic              sdram_read_valid,
    sdram_arbiter_if.master   cmd,
    output logic              ref_overrun
);
    localparam int TMR_W = $clog2(REF_PERIOD);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(REF_PERIOD - 1);
    localparam logic [LEN_W+1:0] RD_SPACE   = (LEN_W+2)'(FIFO_DEPTH);
    localparam int CH_WR = 0;
    localparam int CH_RD = 1;

    state_e                 state;
    logic [TMR_W-1:0]       tmr;
    logic                   ref_pending;
    logic                   tmr_expire;
    logic                   acked;
    logic                   cmd_fin;
    logic                   wr_elig;
    logic                   rd_elig;
    logic                   grant_wr;
    logic [LEN_W+1:0]       rd_sum;
    logic [1:0][ADDR_W-1:0] ptr;
    logic [1:0][ADDR_W-1:0] ptr_min;
    logic [1:0][ADDR_W-1:0] ptr_max;
    logic [1:0][LEN_W-1:0]  ptr_len;
    logic [1:0]             ptr_load;
    logic [1:0]             ptr_done;

    assign wr_elig    = wr_fifo_level >= {1'b0, wr_len};
    assign rd_sum     = {1'b0, rd_fifo_level} + {2'b00, rd_len};
    assign rd_elig    = sdram_read_valid && (rd_sum <= RD_SPACE);
    assign tmr_expire = sdram_init_done && (tmr == '0);
    assign acked      = (state == ST_ISSUE) && sdram_init_done && cmd.cmd_ack;
    // Ack and done may coincide; both complete the command.
    assign cmd_fin    = cmd.cmd_done && ((state == ST_BUSY) || acked);

    assign ptr_min  = {rd_min_addr, wr_min_addr};
    assign ptr_max  = {rd_max_addr, wr_max_addr};
    assign ptr_len  = {rd_len, wr_len};
    assign ptr_load = {rd_load, wr_load};
    assign ptr_done = {cmd_fin && (cmd.cmd_type == CMD_RD),
                       cmd_fin && (cmd.cmd_type == CMD_WR)};

    for (genvar c = 0; c < 2; c++) begin : g_ptr
        sdram_addr_ptr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_ptr (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (ptr_load[c]),
            .done     (ptr_done[c]),
            .min_addr (ptr_min[c]),
            .max_addr (ptr_max[c]),
            .len      (ptr_len[c]),
            .ptr      (ptr[c])
        );
    end

`ifdef SDRAM_ARB_RR_EN
    logic last_was_wr;

    always_comb begin
        grant_wr = wr_elig && (!rd_elig || !last_was_wr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_was_wr <= 1'b0;
        end else if ((state == ST_IDLE) && sdram_init_done && !ref_pending
                     && (wr_elig || rd_elig)) begin
            last_was_wr <= grant_wr;
        end
    end
`else
    always_comb begin
        grant_wr = wr_elig;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr         <= TMR_RELOAD;
            ref_pending <= 1'b0;
            ref_overrun <= 1'b0;
        end else begin
            if (sdram_init_done) begin
                tmr <= (tmr == '0) ? TMR_RELOAD : tmr - 1'b1;
            end
            // A fresh expiry outranks the ack of the previous refresh.
            if (tmr_expire) begin
                ref_pending <= 1'b1;
                if (ref_pending) ref_overrun <= 1'b1;
            end else if (acked && (cmd.cmd_type == CMD_REF)) begin
                ref_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cmd.cmd_req  <= 1'b0;
            cmd.cmd_type <= CMD_REF;
            cmd.cmd_addr <= '0;
            cmd.cmd_len  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sdram_init_done && (ref_pending || wr_elig || rd_elig)) begin
                        state       <= ST_ISSUE;
                        cmd.cmd_req <= 1'b1;
                        if (ref_pending) begin
                            cmd.cmd_type <= CMD_REF;
                            cmd.cmd_addr <= '0;
                            cmd.cmd_len  <= '0;
                        end else if (grant_wr) begin
                            cmd.cmd_type <= CMD_WR;
                            cmd.cmd_addr <= ptr[CH_WR];
                            cmd.cmd_len  <= wr_len;
                        end else begin
                            cmd.cmd_type <= CMD_RD;
                            cmd.cmd_addr <= ptr[CH_RD];
                            cmd.cmd_len  <= rd_len;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!sdram_init_done) begin
                        state       <= ST_IDLE;
                        cmd.cmd_req <= 1'b0;
                    end else if (cmd.cmd_ack) begin
                        cmd.cmd_req <= 1'b0;
                        state       <= cmd.cmd_done ? ST_IDLE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cmd.cmd_done) state <= ST_IDLE;
                end
                default: begin
                    state       <= ST_IDLE;
                    cmd.cmd_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: expected commands are queued as stimulus is set up
// and checked as the engine model accepts them.
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    typedef struct {
        logic [1:0]  t;
        logic [23:0] a;
        logic [9:0]  l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init;
    logic [10:0] wr_level, rd_level;
    logic [23:0] wr_min, wr_max, rd_min, rd_max;
    logic [9:0]  wr_len, rd_len;
    logic        wr_load, rd_load, rd_valid;
    logic        ref_overrun;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc_cnt = 0;
    exp_t exp_q[$];

    sdram_arbiter_if #(.ADDR_W(24), .LEN_W(10)) cif ();

    sdram_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sdram_init_done  (init),
        .wr_fifo_level    (wr_level),
        .rd_fifo_level    (rd_level),
        .wr_min_addr      (wr_min),
        .wr_max_addr      (wr_max),
        .rd_min_addr      (rd_min),
        .rd_max_addr      (rd_max),
        .wr_len           (wr_len),
        .rd_len           (rd_len),
        .wr_load          (wr_load),
        .rd_load          (rd_load),
        .sdram_read_valid (rd_valid),
        .cmd              (cif),
        .ref_overrun      (ref_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [1:0] t, input logic [23:0] a, input logic [9:0] l);
        exp_t e;
        e.t = t; e.a = a; e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; init = 1'b0;
        wr_level = '0; rd_level = '0;
        wr_min = '0; wr_max = 24'd1024; rd_min = '0; rd_max = 24'd4096;
        wr_len = 10'd512; rd_len = 10'd512;
        wr_load = 1'b0; rd_load = 1'b0; rd_valid = 1'b0;
        cif.cmd_ack = 1'b0; cif.cmd_done = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_req(output int cyc);
        cyc = 0;
        while (!cif.cmd_req && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic no_req(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            seen |= cif.cmd_req;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    // done_gap: 0 = done with ack, >0 = done that many cycles after ack, <0 = caller ends it
    task automatic serve(input string tag, input int done_gap);
        int   cyc;
        exp_t e;
        wait_req(cyc);
        chk({tag, "_req"}, 32'(cif.cmd_req), 32'd1);
        if (!cif.cmd_req) return;
        chk({tag, "_sb"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk({tag, "_type"}, 32'(cif.cmd_type), 32'(e.t));
        chk({tag, "_addr"}, 32'(cif.cmd_addr), 32'(e.a));
        chk({tag, "_len"},  32'(cif.cmd_len),  32'(e.l));
        cif.cmd_ack  = 1'b1;
        cif.cmd_done = (done_gap == 0);
        @(negedge clk);
        cif.cmd_ack  = 1'b0;
        cif.cmd_done = 1'b0;
        chk({tag, "_drop"}, 32'(cif.cmd_req), 32'd0);
        if (done_gap > 0) begin
            repeat (done_gap - 1) @(negedge clk);
            cif.cmd_done = 1'b1;
            @(negedge clk);
            cif.cmd_done = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, cyc;
        int t[3];

        // Reset values
        do_reset();
        chk("rst_req",  32'(cif.cmd_req),  32'd0);
        chk("rst_type", 32'(cif.cmd_type), 32'd0);
        chk("rst_addr", 32'(cif.cmd_addr), 32'd0);
        chk("rst_len",  32'(cif.cmd_len),  32'd0);
        chk("rst_ovr",  32'(ref_overrun),  32'd0);

        // Nothing issues before init, then 1-cycle request latency; dropout withdraws it
        wr_level = 11'd512;
        no_req("pre_init", 10);
        init = 1'b1;
        @(negedge clk);
        chk("req_latency", 32'(cif.cmd_req), 32'd1);
        init = 1'b0;
        @(negedge clk);
        chk("dropout_req", 32'(cif.cmd_req), 32'd0);
        no_req("dropout_idle", 5);
        init = 1'b1;
        push(CMD_WR, 24'd0, 10'd512);
        serve("dropout_wr", 1);

        // Refresh cadence
        do_reset();
        init = 1'b1;
        c0 = cyc_cnt;
        for (int i = 0; i < 3; i++) begin
            wait_req(cyc);
            t[i] = cyc_cnt;
            push(CMD_REF, 24'd0, 10'd0);
            serve("ref", 0);
        end
        chk("ref_first",  32'(t[0] - c0),   32'd782);
        chk("ref_period", 32'(t[1] - t[0]), 32'd781);
        chk("ref_period", 32'(t[2] - t[1]), 32'd781);
        chk("ref_no_ovr", 32'(ref_overrun), 32'd0);

        // Write bursts wrapping in [0, 1024)
        do_reset();
        init = 1'b1; wr_level = 11'd512;
        push(CMD_WR, 24'd0,   10'd512);
        push(CMD_WR, 24'd512, 10'd512);
        push(CMD_WR, 24'd0,   10'd512);
        serve("wrap0", 1);
        serve("wrap1", 0);
        serve("wrap2", 3);

        // Read space check
        do_reset();
        rd_min = 24'd256; rd_load = 1'b1;
        @(negedge clk);
        rd_load = 1'b0;
        init = 1'b1; wr_level = 11'd0; rd_len = 10'd512;
        rd_valid = 1'b1; rd_level = 11'd600;
        no_req("rd_full600", 20);
        rd_level = 11'd513;
        no_req("rd_full513", 10);
        rd_valid = 1'b0; rd_level = 11'd0;
        no_req("rd_invalid", 10);
        rd_valid = 1'b1; rd_level = 11'd512;
        push(CMD_RD, 24'd256, 10'd512);
        serve("rd_fit", 1);

        // Contention: read held busy across refresh expiry, then everything eligible
        do_reset();
        init = 1'b1; rd_valid = 1'b1; rd_len = 10'd128; wr_len = 10'd256;
        push(CMD_RD, 24'd0, 10'd128);
        serve("ct_rd0", -1);
        wr_level = 11'd256;
        repeat (800) @(negedge clk);
        cif.cmd_done = 1'b1;
        @(negedge clk);
        cif.cmd_done = 1'b0;
        push(CMD_REF, 24'd0, 10'd0);
`ifdef SDRAM_ARB_RR_EN
        push(CMD_WR, 24'd0,   10'd256);
        push(CMD_RD, 24'd128, 10'd128);
        push(CMD_WR, 24'd256, 10'd256);
        push(CMD_RD, 24'd256, 10'd128);
`else
        push(CMD_WR, 24'd0,   10'd256);
        push(CMD_WR, 24'd256, 10'd256);
        push(CMD_WR, 24'd512, 10'd256);
        push(CMD_WR, 24'd768, 10'd256);
`endif
        for (int i = 0; i < 5; i++) serve("ct", 0);

        // Refresh overrun while the engine withholds ack
        do_reset();
        init = 1'b1;
        wait_req(cyc);
        chk("ovr_type", 32'(cif.cmd_type), 32'(CMD_REF));
        chk("ovr_early", 32'(ref_overrun), 32'd0);
        repeat (1600) @(negedge clk);
        chk("ovr_held", 32'(cif.cmd_req), 32'd1);
        chk("ovr_set",  32'(ref_overrun), 32'd1);
        push(CMD_REF, 24'd0, 10'd0);
        serve("ovr_ref", 0);
        repeat (3) @(negedge clk);
        chk("ovr_sticky", 32'(ref_overrun), 32'd1);

        // Load colliding with a write's done wins over the increment
        do_reset();
        init = 1'b1; wr_level = 11'd512; wr_max = 24'd2048;
        push(CMD_WR, 24'd0,   10'd512);
        push(CMD_WR, 24'd512, 10'd512);
        serve("lc_w0", 0);
        serve("lc_w1", -1);
        cif.cmd_done = 1'b1; wr_load = 1'b1;
        @(negedge clk);
        cif.cmd_done = 1'b0; wr_load = 1'b0;
        push(CMD_WR, 24'd0, 10'd512);
        serve("lc_w2", 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
